mul_hilo_unit: RTL and testbench

Iterative multiply unit with HI/LO registers that sequences the `mult`, `mflo` and `mfhi` operations decoded by the ALU decoder (ALUControl 3'b011, 3'b101, 3'b100). It sits beside the main ALU in the execute path. On `mult` it runs a radix-2 shift-add sequence over several cycles, then commits the 2·WIDTH product to HI/LO. While the unit is busy it stalls the core for any further multiply or HI/LO read.

---
 rtl/mul_pkg.sv | 14 +
 rtl/mul_hilo_unit_if.sv | 24 ++
 rtl/mul_datapath.sv | 61 ++++++
 rtl/mul_hilo_unit.sv | 89 ++++++++
 tb/tb_mul_hilo_unit.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Opcodes, FSM state type and decode helper shared by the mul_hilo_unit files.
package mul_pkg;

  localparam logic [2:0] ALU_MULT = 3'b011;
  localparam logic [2:0] ALU_MFLO = 3'b101;
  localparam logic [2:0] ALU_MFHI = 3'b100;

  typedef enum logic [1:0] {IDLE, RUN, FIX} mul_state_t;

  function automatic logic is_hilo_op(input logic [2:0] ctl);
    return (ctl == ALU_MULT) || (ctl == ALU_MFLO) || (ctl == ALU_MFHI);
  endfunction

endpackage

// File: rtl/mul_hilo_unit_if.sv
// Execute-stage request/response bundle between the core and mul_hilo_unit.
interface mul_hilo_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             op_valid;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] Result;
  logic             stall;
  logic             busy;

  modport master (
    output op_valid, ALUControl, SrcA, SrcB,
    input  Result, stall, busy
  );

  modport slave (
    input  op_valid, ALUControl, SrcA, SrcB,
    output Result, stall, busy
  );

endinterface

// File: rtl/mul_datapath.sv
// Radix-2 shift-add multiplier datapath; signed operation when MULT_SIGNED_EN is defined.
module mul_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sign_in;
  logic [WIDTH:0]     sum;

`ifdef MULT_SIGNED_EN
  assign mag_a   = op_a[WIDTH-1] ? (-op_a) : op_a;
  assign mag_b   = op_b[WIDTH-1] ? (-op_b) : op_b;
  assign sign_in = op_a[WIDTH-1] ^ op_b[WIDTH-1];
`else
  assign mag_a   = op_a;
  assign mag_b   = op_b;
  assign sign_in = 1'b0;
`endif

  // Upper half accumulates; lower half starts as the multiplier and shifts out LSB-first.
  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    if (load) begin
      acc_d   = {{WIDTH{1'b0}}, mag_b};
      mcand_d = mag_a;
      neg_d   = sign_in;
    end else if (step) begin
      acc_d = {sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
    end
  end

  assign product = (fix && neg_q) ? (-acc_q) : acc_q;

endmodule

// File: rtl/mul_hilo_unit.sv
// Iterative mult/mflo/mfhi unit with HI/LO; FSM, counter and stall logic around mul_datapath.
// Signed multiply is enabled by defining MULT_SIGNED_EN.
module mul_hilo_unit
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  mul_hilo_unit_if.slave   bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  mul_state_t         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [2*WIDTH-1:0] product;
  logic               load, step, fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.op_valid && bus.ALUControl == ALU_MULT) begin
          state_d = RUN;
          cnt_d   = CntW'(WIDTH);
        end
      end
      RUN: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reads are only served from IDLE; any mult/HI/LO op while busy is held off.
  always_comb begin
    load       = (state_q == IDLE) && bus.op_valid && (bus.ALUControl == ALU_MULT);
    step       = (state_q == RUN);
    fix        = (state_q == FIX);
    bus.busy   = (state_q != IDLE);
    bus.stall  = bus.op_valid && is_hilo_op(bus.ALUControl) && (state_q != IDLE);
    bus.Result = '0;
    if (bus.op_valid && state_q == IDLE) begin
      case (bus.ALUControl)
        ALU_MFLO: bus.Result = lo_q;
        ALU_MFHI: bus.Result = hi_q;
        default:  bus.Result = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (fix) begin
      {hi_q, lo_q} <= product;
    end
  end

  mul_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .fix     (fix),
    .op_a    (bus.SrcA),
    .op_b    (bus.SrcB),
    .product (product)
  );

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Directed self-checking bench for mul_hilo_unit: reset, latency, stalls, signed/unsigned, abort.
module tb_mul_hilo_unit;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   n;

  mul_hilo_unit_if #(.WIDTH(32)) bus ();

  mul_hilo_unit #(
    .WIDTH (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] ctl, input logic [31:0] a,
                       input logic [31:0] b);
    bus.op_valid   = v;
    bus.ALUControl = ctl;
    bus.SrcA       = a;
    bus.SrcB       = b;
    #1;
  endtask

  // Accept a mult, then count busy cycles until the product commits.
  task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b);
    int cnt;
    drive(1'b1, ALU_MULT, a, b);
    chk({tag, "_accept_stall"}, {63'd0, bus.stall}, 64'd0);
    cycle();
    drive(1'b0, 3'b000, '0, '0);
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      cnt++;
      cycle();
    end
    chk({tag, "_busy_cycles"}, 64'(cnt), 64'd33);
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    drive(1'b1, ALU_MFLO, '0, '0);
    chk({tag, "_lo"}, {32'd0, bus.Result}, {32'd0, exp_lo});
    chk({tag, "_lo_stall"}, {63'd0, bus.stall}, 64'd0);
    drive(1'b1, ALU_MFHI, '0, '0);
    chk({tag, "_hi"}, {32'd0, bus.Result}, {32'd0, exp_hi});
    drive(1'b0, 3'b000, '0, '0);
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 3'b000, '0, '0);
    rst_n = 1'b0;
    #1;
    repeat (3) cycle();
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_stall", {63'd0, bus.stall}, 64'd0);
    rst_n = 1'b1;
    cycle();
    read_hilo("after_reset", 32'd0, 32'd0);

    // Non-hilo opcode never produces a result or stall.
    drive(1'b1, 3'b010, 32'd5, 32'd6);
    chk("other_op_result", {32'd0, bus.Result}, 64'd0);
    drive(1'b0, 3'b000, '0, '0);

    do_mult("m7x6", 32'd7, 32'd6);
    read_hilo("m7x6", 32'd42, 32'd0);

    do_mult("mneg", 32'hFFFF_FFFD, 32'd5);
`ifdef MULT_SIGNED_EN
    read_hilo("mneg", 32'hFFFF_FFF1, 32'hFFFF_FFFF);
`else
    read_hilo("mneg", 32'hFFFF_FFF1, 32'h0000_0004);
`endif

    // mflo presented in the fourth busy cycle is held for 30 cycles.
    drive(1'b1, ALU_MULT, 32'd9, 32'd11);
    cycle();
    drive(1'b0, 3'b000, '0, '0);
    repeat (3) cycle();
    drive(1'b1, ALU_MFLO, '0, '0);
    n = 0;
    while (bus.stall && n < 100) begin
      n++;
      cycle();
    end
    chk("mflo_stall_cycles", 64'(n), 64'd30);
    chk("mflo_after_stall", {32'd0, bus.Result}, 64'd99);
    chk("mflo_busy_clear", {63'd0, bus.busy}, 64'd0);
    drive(1'b0, 3'b000, '0, '0);

    // Second mult issued while the first is in flight.
    drive(1'b1, ALU_MULT, 32'd7, 32'd6);
    cycle();
    drive(1'b1, ALU_MULT, 32'd3, 32'd4);
    n = 0;
    while (bus.stall && n < 100) begin
      n++;
      cycle();
    end
    chk("mult2_stall_cycles", 64'(n), 64'd33);
    drive(1'b1, ALU_MFLO, '0, '0);
    chk("mult2_first_intact", {32'd0, bus.Result}, 64'd42);
    drive(1'b1, ALU_MULT, 32'd3, 32'd4);
    chk("mult2_accept_stall", {63'd0, bus.stall}, 64'd0);
    cycle();
    drive(1'b0, 3'b000, '0, '0);
    chk("mult2_busy", {63'd0, bus.busy}, 64'd1);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      cycle();
    end
    chk("mult2_busy_cycles", 64'(n), 64'd33);
    read_hilo("mult2", 32'd12, 32'd0);

    // Asynchronous abort in the middle of RUN.
    drive(1'b1, ALU_MULT, 32'd100, 32'd100);
    cycle();
    drive(1'b0, 3'b000, '0, '0);
    repeat (9) cycle();
    chk("abort_busy_before", {63'd0, bus.busy}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    read_hilo("abort", 32'd0, 32'd0);
    cycle();
    rst_n = 1'b1;
    cycle();
    do_mult("m2x2", 32'd2, 32'd2);
    read_hilo("m2x2", 32'd4, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
